// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file with busy scoreboard.
// Defaults describe the operand store used by the issue/writeback datapath.
package regfile_mp_sb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    typedef enum logic {
        RD_COMB = 1'b0,
        RD_REG  = 1'b1
    } rd_mode_e;

    // Bits needed to hold values 0..value-1; used to size the busy counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Issue/writeback bus of the register file: read ports, write ports, scoreboard alloc and count.
// The datapath drives it through the master modport; the register file sits on the slave side.
interface regfile_mp_sb_if
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_mp_sb_wr_sel.sv
// Priority select over the write ports for one address: reports whether any enabled port
// targets it and the data of the highest-index such port (that port wins a conflict).
module regfile_mp_sb_wr_sel
    import regfile_mp_sb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    // Later ports overwrite earlier matches, giving the highest index priority.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[w*DATA_W +: DATA_W];
            end else begin
                hit_o  = hit_o;
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass, optional registered reads, optional
// hardwired-zero register 0 and a per-register busy scoreboard with a running busy count.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_RD     = NUM_RD_DEF,
    parameter int NUM_WR     = NUM_WR_DEF,
    parameter int ZERO_REG   = 1,
    parameter int RD_LATENCY = 0
) (
    input  logic            clk,
    input  logic            rst,
    regfile_mp_sb_if.slave  rf_if
);

    localparam int       DEPTH   = 2 ** ADDR_W;
    localparam int       CNT_W   = clog2(DEPTH + 1);
    localparam rd_mode_e RD_MODE = (RD_LATENCY == 1) ? RD_REG : RD_COMB;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wr_val_s [DEPTH];
    logic [DEPTH-1:0]  wr_hit_s;
    logic [DEPTH-1:0]  set_s;
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  busy_cnt_q;
    logic [CNT_W-1:0]  busy_cnt_d;
    logic [CNT_W-1:0]  cnt_dec_s;
    logic              cnt_inc_s;

    // Per-address write decode; register 0 is masked out when it is hardwired to zero.
    for (genvar a = 0; a < DEPTH; a++) begin : g_slot
        localparam bit ZERO_SLOT = (ZERO_REG != 0) && (a == 0);
        logic hit_s;

        regfile_mp_sb_wr_sel #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .NUM_WR (NUM_WR)
        ) u_wr_dec (
            .addr_i    (ADDR_W'(a)),
            .wr_en_i   (rf_if.wr_en),
            .wr_addr_i (rf_if.wr_addr),
            .wr_data_i (rf_if.wr_data),
            .hit_o     (hit_s),
            .data_o    (wr_val_s[a])
        );

        assign wr_hit_s[a] = hit_s && !ZERO_SLOT;
        assign set_s[a]    = rf_if.alloc_en && (rf_if.alloc_addr == ADDR_W'(a)) && !ZERO_SLOT;
    end

    // Storage array: winning write per address commits at the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit_s[i]) begin
                    mem_q[i] <= wr_val_s[i];
                end
            end
        end
    end

    // Scoreboard next state: alloc beats a same-cycle writeback since a new producer is pending.
    always_comb begin
        busy_d    = (busy_q & ~wr_hit_s) | set_s;
        cnt_inc_s = |(set_s & ~busy_q);
        cnt_dec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && wr_hit_s[i] && !set_s[i]) begin
                cnt_dec_s = cnt_dec_s + CNT_W'(1);
            end else begin
                cnt_dec_s = cnt_dec_s;
            end
        end
        busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc_s) - cnt_dec_s;
    end

    // Scoreboard and busy counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rf_if.busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic              byp_hit_s;
        logic [DATA_W-1:0] byp_data_s;
        logic [DATA_W-1:0] rd_val_s;
        logic              rd_busy_s;

        assign ra_s = rf_if.rd_addr[p*ADDR_W +: ADDR_W];

        regfile_mp_sb_wr_sel #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .NUM_WR (NUM_WR)
        ) u_bypass (
            .addr_i    (ra_s),
            .wr_en_i   (rf_if.wr_en),
            .wr_addr_i (rf_if.wr_addr),
            .wr_data_i (rf_if.wr_data),
            .hit_o     (byp_hit_s),
            .data_o    (byp_data_s)
        );

        // Read mux: zero register, then same-cycle write bypass (which also clears busy), then storage.
        always_comb begin
            if ((ZERO_REG != 0) && (ra_s == ADDR_W'(0))) begin
                rd_val_s  = '0;
                rd_busy_s = 1'b0;
            end else if (byp_hit_s) begin
                rd_val_s  = byp_data_s;
                rd_busy_s = 1'b0;
            end else begin
                rd_val_s  = mem_q[ra_s];
                rd_busy_s = busy_q[ra_s];
            end
        end

        if (RD_MODE == RD_REG) begin : g_lat1
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_busy_q;

            // Output register captures the bypassed value so edge-N writes are already visible.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q <= '0;
                    rd_busy_q <= 1'b0;
                end else begin
                    rd_data_q <= rd_val_s;
                    rd_busy_q <= rd_busy_s;
                end
            end

            assign rf_if.rd_data[p*DATA_W +: DATA_W] = rd_data_q;
            assign rf_if.rd_busy[p]                  = rd_busy_q;
        end else begin : g_lat0
            assign rf_if.rd_data[p*DATA_W +: DATA_W] = rd_val_s;
            assign rf_if.rd_busy[p]                  = rd_busy_s;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: one combinational-read and one registered-read instance
// share the same stimulus; expected responses are queued and checked by a separate monitor.
module tb_regfile_mp_sb;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             alloc_en;
    logic [AW-1:0]    alloc_addr;

    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) if0 ();
    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) if1 ();

    assign if0.rd_addr = rd_addr;   assign if1.rd_addr = rd_addr;
    assign if0.wr_en = wr_en;       assign if1.wr_en = wr_en;
    assign if0.wr_addr = wr_addr;   assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;   assign if1.wr_data = wr_data;
    assign if0.alloc_en = alloc_en; assign if1.alloc_en = alloc_en;
    assign if0.alloc_addr = alloc_addr; assign if1.alloc_addr = alloc_addr;

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                    .ZERO_REG(1), .RD_LATENCY(0)) dut0 (.clk(clk), .rst(rst), .rf_if(if0.slave));
    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                    .ZERO_REG(1), .RD_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .rf_if(if1.slave));

    // kinds: 0 lat0 data, 1 lat0 busy, 2 lat0 cnt, 3 lat1 data, 4 lat1 busy, 5 lat1 cnt
    typedef struct {
        int          due;
        int          kind;
        int          idx;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t keep_q[$];
    exp_t e_m;
    logic [15:0] act_m;
    int n_vec = 0;
    int n_err = 0;

    function automatic string kind_name(input int k);
        case (k)
            0: return "lat0_rd_data";
            1: return "lat0_rd_busy";
            2: return "lat0_busy_cnt";
            3: return "lat1_rd_data";
            4: return "lat1_rd_busy";
            5: return "lat1_busy_cnt";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [15:0] actual(input int k, input int idx);
        case (k)
            0: return if0.rd_data[idx*DW +: DW];
            1: return {15'd0, if0.rd_busy[idx]};
            2: return {10'd0, if0.busy_cnt};
            3: return if1.rd_data[idx*DW +: DW];
            4: return {15'd0, if1.rd_busy[idx]};
            5: return {10'd0, if1.busy_cnt};
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic expect_v(input int k, input int idx, input logic [15:0] val);
        exp_t e;
        e.due  = (k == 3 || k == 4) ? cyc + 1 : cyc;
        e.kind = k;
        e.idx  = idx;
        e.exp  = val;
        sb_q.push_back(e);
    endtask

    task automatic expect_cnt(input logic [15:0] val);
        expect_v(2, 0, val);
        expect_v(5, 0, val);
    endtask

    // Monitor: compare every expectation that falls due this cycle, away from the active edge.
    always @(negedge clk) begin
        keep_q.delete();
        for (int i = 0; i < sb_q.size(); i++) begin
            e_m = sb_q[i];
            if (e_m.due == cyc) begin
                act_m = actual(e_m.kind, e_m.idx);
                n_vec++;
                if (act_m !== e_m.exp) begin
                    n_err++;
                    $display("FAIL %s port%0d cycle %0d: got %h expected %h",
                             kind_name(e_m.kind), e_m.idx, cyc, act_m, e_m.exp);
                end
            end else if (e_m.due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s port%0d overdue at cycle %0d", kind_name(e_m.kind), e_m.idx, cyc);
            end else begin
                keep_q.push_back(e_m);
            end
        end
        sb_q = keep_q;
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[port]            = 1'b1;
        wr_addr[port*AW +: AW] = a;
        wr_data[port*DW +: DW] = d;
    endtask

    task automatic alloc(input logic [AW-1:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    initial begin
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state across every address on both read ports
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            rd(AW'(a), AW'(31 - a));
            expect_v(0, 0, 16'h0000); expect_v(0, 1, 16'h0000);
            expect_v(1, 0, 16'h0000); expect_v(1, 1, 16'h0000);
            expect_v(3, 0, 16'h0000); expect_v(4, 1, 16'h0000);
            expect_cnt(16'd0);
        end

        // Reset mid-operation
        next_cycle();
        wr(0, 5'd4, 16'h1234); alloc(5'd8); rd(5'd4, 5'd8);
        expect_v(0, 0, 16'h1234); expect_v(1, 0, 16'd0);
        expect_v(0, 1, 16'h0000); expect_v(1, 1, 16'd0);
        expect_v(3, 0, 16'h1234); expect_v(4, 1, 16'd0);
        expect_cnt(16'd0);
        next_cycle();
        wr(0, 5'd4, 16'h5678); rd(5'd4, 5'd8);
        expect_v(0, 0, 16'h5678); expect_v(1, 1, 16'd1);
        expect_cnt(16'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        rd(5'd4, 5'd8);
        expect_v(0, 0, 16'h0000); expect_v(1, 1, 16'd0);
        expect_v(3, 0, 16'h0000); expect_v(4, 1, 16'd0);
        expect_cnt(16'd0);

        // Bypass and stored value
        next_cycle();
        wr(0, 5'd3, 16'hA5A5); rd(5'd3, 5'd0);
        expect_v(0, 0, 16'hA5A5); expect_v(0, 1, 16'h0000); expect_v(3, 0, 16'hA5A5);
        next_cycle();
        rd(5'd3, 5'd0);
        expect_v(0, 0, 16'hA5A5);

        // Same-address write conflict: port 1 wins
        next_cycle();
        wr(0, 5'd7, 16'h1111); wr(1, 5'd7, 16'h2222); rd(5'd3, 5'd7);
        expect_v(0, 1, 16'h2222); expect_v(0, 0, 16'hA5A5); expect_v(3, 1, 16'h2222);
        next_cycle();
        rd(5'd7, 5'd3);
        expect_v(0, 0, 16'h2222);

        // Hardwired zero register
        next_cycle();
        wr(0, 5'd0, 16'hFFFF); alloc(5'd0); rd(5'd0, 5'd7);
        expect_v(0, 0, 16'h0000); expect_v(1, 0, 16'd0);
        expect_v(3, 0, 16'h0000); expect_v(4, 0, 16'd0);
        next_cycle();
        rd(5'd0, 5'd7);
        expect_v(0, 0, 16'h0000); expect_v(1, 0, 16'd0); expect_cnt(16'd0);

        // Scoreboard
        next_cycle(); alloc(5'd5); expect_cnt(16'd0);
        next_cycle(); alloc(5'd6); expect_cnt(16'd1);
        next_cycle();
        wr(0, 5'd5, 16'h0505); alloc(5'd5); rd(5'd5, 5'd6);
        expect_cnt(16'd2);
        expect_v(1, 0, 16'd0); expect_v(1, 1, 16'd1); expect_v(0, 0, 16'h0505);
        expect_v(4, 0, 16'd0); expect_v(4, 1, 16'd1);
        next_cycle();
        wr(0, 5'd6, 16'h0606); rd(5'd5, 5'd6);
        expect_cnt(16'd2);
        expect_v(1, 0, 16'd1); expect_v(1, 1, 16'd0); expect_v(0, 1, 16'h0606);
        expect_v(4, 0, 16'd1); expect_v(4, 1, 16'd0); expect_v(3, 1, 16'h0606);
        next_cycle();
        alloc(5'd5); rd(5'd5, 5'd6);
        expect_cnt(16'd1); expect_v(1, 0, 16'd1); expect_v(1, 1, 16'd0);
        next_cycle();
        alloc(5'd12); rd(5'd12, 5'd5);
        expect_cnt(16'd1); expect_v(1, 0, 16'd0); expect_v(1, 1, 16'd1);
        next_cycle();
        wr(0, 5'd5, 16'h5555); wr(1, 5'd12, 16'h1212); rd(5'd5, 5'd12);
        expect_cnt(16'd2);
        expect_v(1, 0, 16'd0); expect_v(1, 1, 16'd0);
        expect_v(0, 0, 16'h5555); expect_v(0, 1, 16'h1212);
        next_cycle();
        rd(5'd5, 5'd12);
        expect_cnt(16'd0); expect_v(0, 0, 16'h5555); expect_v(0, 1, 16'h1212);
        next_cycle(); alloc(5'd13); expect_cnt(16'd0);
        next_cycle();
        wr(0, 5'd13, 16'h000D); wr(1, 5'd13, 16'h0D0D); rd(5'd13, 5'd12);
        expect_cnt(16'd1); expect_v(0, 0, 16'h0D0D); expect_v(1, 0, 16'd0);
        next_cycle();
        rd(5'd13, 5'd12);
        expect_cnt(16'd0); expect_v(0, 0, 16'h0D0D);

        // Registered read sees the write committed at the same edge
        next_cycle();
        wr(0, 5'd9, 16'h0042); rd(5'd9, 5'd3);
        expect_v(0, 0, 16'h0042);
        expect_v(3, 0, 16'h0042); expect_v(4, 0, 16'd0); expect_v(3, 1, 16'hA5A5);
        next_cycle();
        rd(5'd9, 5'd3);
        expect_v(0, 0, 16'h0042); expect_cnt(16'd0);

        repeat (4) next_cycle();
        for (int i = 0; i < sb_q.size(); i++) begin
            n_vec++;
            n_err++;
            $display("FAIL %s port%0d never checked", kind_name(sb_q[i].kind), sb_q[i].idx);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
